// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU codes, FSM states and field widths for the control unit.
package cpu_pkg;
  localparam int PC_W   = 5;
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int IMM_W  = 5;
  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LDI  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b010;
  localparam logic [OP_W-1:0] OP_SUBI = 3'b011;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b100;
  localparam logic [OP_W-1:0] OP_JZ   = 3'b101;
  localparam logic [OP_W-1:0] OP_OUT  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_OUTPUT, S_HALT} state_t;
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return op == OP_LDI || op == OP_ADDI || op == OP_SUBI;
  endfunction
endpackage

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle accumulator CPU sequencer driving external imem and ALU.
// Define CU_SINGLE_STEP_EN to add a step input that gates each instruction fetch.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 5'd0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              halted
);
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, acc_q, acc_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic z_q, z_d, imem_rd_q, imem_rd_d, out_valid_q, out_valid_d, halted_q, halted_d;
  logic [OP_W-1:0] op;
  logic [IMM_W-1:0] imm;
  logic fetch_done, out_done, arith, alu_go;
`ifdef CU_SINGLE_STEP_EN
  logic step_seen_q, step_seen_d;
`endif
  assign op = ir_q[DATA_W-1:IMM_W];
  assign imm = ir_q[IMM_W-1:0];
  always_comb begin
    fetch_done = state_q == S_FETCH && imem_rd_q && imem_valid;
    out_done = state_q == S_OUTPUT && out_valid_q && out_ready;
    arith = is_arith(op);
    state_d = state_q == S_FETCH ? (fetch_done ? S_DECODE : S_FETCH)
            : state_q == S_DECODE ? (op == OP_HALT ? S_HALT : op == OP_OUT ? S_OUTPUT : S_EXEC)
            : state_q == S_EXEC ? S_FETCH
            : state_q == S_OUTPUT ? (out_done ? S_FETCH : S_OUTPUT)
            : S_HALT;
    ir_d = fetch_done ? imem_data : ir_q;
    pc_d = fetch_done ? pc_q + 1'b1
         : state_q == S_EXEC && (op == OP_JMP || (op == OP_JZ && z_q)) ? imm : pc_q;
    acc_d = state_q == S_EXEC && arith ? alu_result : acc_q;
    z_d = state_q == S_EXEC && arith ? alu_zero : z_q;
    // Operands are registered on DECODE->EXEC so the external ALU sees them for the whole EXEC cycle.
    alu_go = state_d == S_EXEC && arith;
    alu_a_d = alu_go && op != OP_LDI ? acc_q : '0;
    alu_b_d = alu_go ? {{(DATA_W-IMM_W){1'b0}}, imm} : '0;
    alu_op_d = alu_go && op == OP_SUBI ? ALU_SUB : ALU_ADD;
`ifdef CU_SINGLE_STEP_EN
    step_seen_d = state_q == S_FETCH && state_d == S_FETCH && (step_seen_q || step);
    imem_rd_d = step_seen_d;
`else
    imem_rd_d = state_d == S_FETCH;
`endif
    out_valid_d = state_d == S_OUTPUT;
    halted_d = state_d == S_HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      acc_q <= '0;
      z_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      imem_rd_q <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q <= 1'b0;
`ifdef CU_SINGLE_STEP_EN
      step_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      acc_q <= acc_d;
      z_q <= z_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_op_q <= alu_op_d;
      imem_rd_q <= imem_rd_d;
      out_valid_q <= out_valid_d;
      halted_q <= halted_d;
`ifdef CU_SINGLE_STEP_EN
      step_seen_q <= step_seen_d;
`endif
    end
  end
  assign imem_addr = pc_q;
  assign imem_rd = imem_rd_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_op = alu_op_q;
  assign out_data = acc_q;
  assign out_valid = out_valid_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed programs against cpu_control_unit with a bench-side memory and ALU.
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] imem_addr;
  logic imem_rd, imem_valid, alu_zero, out_valid, out_ready, halted;
  logic [7:0] imem_data, alu_a, alu_b, alu_result, out_data;
  logic [2:0] alu_op;
  logic [7:0] mem [32];
  logic spurious = 1'b0;
  int lat = 0;
  int rd_cnt = 0;
  int xfers = 0;
  int base;
  int n_vec = 0;
  int n_err = 0;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_valid(imem_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  assign imem_valid = (imem_rd && rd_cnt >= lat) || spurious;
  assign alu_result = alu_op == 3'b001 ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zero = alu_result == 8'd0;
  always @(posedge clk) rd_cnt <= imem_rd ? rd_cnt + 1 : 0;
  always @(posedge clk) if (out_valid && out_ready) xfers <= xfers + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_clear();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spurious = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic next_fetch(input string tag, input logic [4:0] a);
    int n = 0;
    do begin tick(1); n++; end while (!imem_rd && n < 30);
    chk({tag, "_rd"}, imem_rd, 1);
    chk(tag, imem_addr, a);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 60) begin tick(1); n++; end
    chk({tag, "_ov"}, out_valid, 1);
  endtask

  initial begin
    out_ready = 1'b1;
    // reset state and LDI 5, ADDI 3, OUT, HALT with exact cycle timing
    load_clear();
    mem[0] = 8'h25; mem[1] = 8'h43; mem[2] = 8'hC0; mem[3] = 8'hE0;
    tick(2);
    chk("rst_rd", imem_rd, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_halt", halted, 0);
    chk("rst_od", out_data, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
    chk("rst_addr", imem_addr, 0);
    base = xfers;
    do_reset();
    tick(1); chk("f0_rd", imem_rd, 1); chk("f0_addr", imem_addr, 0);
    tick(1); chk("d0_rd", imem_rd, 0); chk("d0_alu", {alu_a, alu_b, alu_op}, 0);
    tick(1); chk("ldi_a", alu_a, 0); chk("ldi_b", alu_b, 5); chk("ldi_op", alu_op, 0);
    tick(1); chk("f1_rd", imem_rd, 1); chk("f1_addr", imem_addr, 1); chk("f1_alu", {alu_a, alu_b, alu_op}, 0);
    tick(2); chk("addi_a", alu_a, 5); chk("addi_b", alu_b, 3); chk("addi_op", alu_op, 0);
    tick(1); chk("f2_addr", imem_addr, 2);
    tick(2); chk("out_v", out_valid, 1); chk("out_d", out_data, 8);
    tick(1); chk("post_out_v", out_valid, 0); chk("f3_rd", imem_rd, 1); chk("f3_addr", imem_addr, 3);
    tick(2); chk("halt", halted, 1); chk("halt_rd", imem_rd, 0);
    tick(3); chk("halt_hold", halted, 1); chk("halt_rd_hold", imem_rd, 0);
    chk("p1_xfers", xfers - base, 1);

    // JZ taken after LDI 2, SUBI 2
    load_clear();
    mem[0] = 8'h22; mem[1] = 8'h62; mem[2] = 8'hA7; mem[7] = 8'hC0; mem[8] = 8'hE0;
    do_reset();
    next_fetch("jz_f0", 0); next_fetch("jz_f1", 1); next_fetch("jz_f2", 2);
    next_fetch("jz_taken", 7);
    wait_out("jz"); chk("jz_acc", out_data, 0);

    // JZ not taken after LDI 2, SUBI 1
    load_clear();
    mem[0] = 8'h22; mem[1] = 8'h61; mem[2] = 8'hA7; mem[3] = 8'hC0; mem[4] = 8'hE0;
    do_reset();
    next_fetch("nz_f0", 0); next_fetch("nz_f1", 1); next_fetch("nz_f2", 2);
    next_fetch("nz_fall", 3);
    wait_out("nz"); chk("nz_acc", out_data, 1);

    // LDI 1, SUBI 2 wraps to FF with Z=0; JMP 31 then PC wraps to 0
    load_clear();
    mem[0] = 8'h21; mem[1] = 8'h62; mem[2] = 8'hA7; mem[3] = 8'hC0; mem[4] = 8'h9F;
    do_reset();
    next_fetch("wr_f0", 0); next_fetch("wr_f1", 1);
    tick(2); chk("sub_a", alu_a, 1); chk("sub_b", alu_b, 2); chk("sub_op", alu_op, 1);
    next_fetch("wr_f2", 2); next_fetch("wr_z0", 3);
    wait_out("wr"); chk("wr_acc", out_data, 8'hFF);
    next_fetch("wr_f4", 4); next_fetch("wr_f31", 31); next_fetch("wr_pc_wrap", 0);

    // OUT held 4 cycles without ready, stray imem_valid ignored
    load_clear();
    mem[0] = 8'h29; mem[1] = 8'hC0; mem[2] = 8'hE0;
    out_ready = 1'b0;
    do_reset();
    wait_out("hold");
    base = xfers;
    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_v%0d", i), out_valid, 1);
      chk($sformatf("hold_d%0d", i), out_data, 9);
      tick(1);
    end
    spurious = 1'b0;
    out_ready = 1'b1;
    tick(1); chk("hold_done", out_valid, 0); chk("hold_xfers", xfers - base, 1);
    tick(4); chk("hold_halt", halted, 1); chk("hold_xfers_end", xfers - base, 1);

    // slow memory, then reset during OUTPUT
    load_clear();
    mem[0] = 8'h24; mem[1] = 8'hC0; mem[2] = 8'hE0;
    lat = 3;
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("slow_rd%0d", i), imem_rd, 1);
      chk($sformatf("slow_addr%0d", i), imem_addr, 0);
    end
    wait_out("slow"); chk("slow_acc", out_data, 4);
    rst = 1'b1;
    mem[0] = 8'hC0;
    lat = 0;
    tick(1);
    chk("mid_rst_ov", out_valid, 0); chk("mid_rst_rd", imem_rd, 0);
    chk("mid_rst_addr", imem_addr, 0); chk("mid_rst_halt", halted, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_op}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(1); chk("rel_rd", imem_rd, 1); chk("rel_addr", imem_addr, 0);
    wait_out("rel"); chk("rel_acc", out_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter RESET_PC, default 5'd0, program-counter value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_addr  output  5  instruction address, equals PC.
REQ-005 imem_rd  output  1  instruction read request.
REQ-006 imem_data  input  8  instruction word: [7:5] op, [4:0] imm/addr.
REQ-007 imem_valid  input  1  imem_data valid; completes the read.
REQ-008 alu_a  output  8  ALU operand A.
REQ-009 alu_b  output  8  ALU operand B.
REQ-010 alu_op  output  3  ALU opcode: 000 ADD, 001 SUB.
REQ-011 alu_result  input  8  combinational ALU result.
REQ-012 alu_zero  input  1  combinational ALU zero flag.
REQ-013 out_data  output  8  accumulator value for OUT.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 halted  output  1  core is in HALT.

Function
REQ-017 States: FETCH, DECODE, EXEC, OUTPUT, HALT, held in a registered state variable.
REQ-018 FETCH: imem_rd=1, imem_addr=PC; stay until imem_valid=1; then latch IR, PC <= PC+1 (5-bit wrap 31->0), go to DECODE.
REQ-019 DECODE: one cycle; go to HALT for op 111, OUTPUT for op 110, else EXEC.
REQ-020 Ops: 000 NOP; 001 LDI acc=0+imm; 010 ADDI acc=acc+imm; 011 SUBI acc=acc-imm; 100 JMP PC=addr; 101 JZ PC=addr if Z=1; 110 OUT; 111 HALT.
REQ-021 imm zero-extended to 8 bits; arithmetic modulo 256, no carry/borrow kept.
REQ-022 EXEC for LDI/ADDI/SUBI: drive alu_a (0 for LDI, else acc), alu_b=imm, alu_op (ADD for LDI/ADDI, SUB for SUBI); on that edge acc <= alu_result, Z <= alu_zero.
REQ-023 alu_a/alu_b/alu_op SHALL be 0 in every cycle other than an arithmetic EXEC.
REQ-024 NOP, JMP, JZ SHALL NOT alter acc or Z; JZ with Z=0 leaves PC unchanged.
REQ-025 EXEC lasts one cycle, then FETCH; arithmetic/jump instruction latency is 3 cycles with imem_valid returned in the first FETCH cycle.
REQ-026 OUTPUT: out_valid=1, out_data=acc, held stable until out_ready=1; transfer on that edge, then FETCH.
REQ-027 out_ready while out_valid=0 SHALL be ignored.
REQ-028 HALT: halted=1, imem_rd=0; remain until rst.
REQ-029 imem_valid outside FETCH SHALL be ignored.

Reset
REQ-030 rst=1 at any edge, including mid-FETCH or mid-OUTPUT: state=FETCH, PC=RESET_PC, IR=0, acc=0, Z=0.
REQ-031 While rst=1: imem_rd=0, out_valid=0, halted=0, out_data=0, alu_a/alu_b/alu_op=0; first read issued the cycle after rst falls.

Configuration
REQ-032 Macro CU_SINGLE_STEP_EN: when defined, adds input step (1 bit); FETCH SHALL not assert imem_rd until a cycle with step=1 has been seen since the last FETCH entry.
REQ-033 Without CU_SINGLE_STEP_EN: no step port; FETCH requests immediately.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the instruction-opcode constants, ALU opcode constants (ADD=000, SUB=001), state enumeration and field widths.
REQ-035 No sub-module; ALU instantiated externally and connected through alu_* ports.

Verification
REQ-036 Program LDI 5, ADDI 3, OUT, HALT with zero-wait memory -> out_data=8'd8 with out_valid; halted=1 afterwards.
REQ-037 LDI 2, SUBI 2, JZ 7 -> Z=1, acc=0, next imem_addr=7; with LDI 2, SUBI 1, JZ 7 -> next imem_addr=3.
REQ-038 LDI 1, SUBI 2 -> acc=8'hFF, Z=0 (wrap); PC 31 fetch NOP -> next imem_addr=0.
REQ-039 OUT with out_ready low 4 cycles -> out_valid and out_data stable for 4 cycles, one transfer on ready.
REQ-040 imem_valid delayed 3 cycles, rst pulsed during OUTPUT -> imem_rd held meanwhile; after reset imem_addr=RESET_PC, acc=0, out_valid=0.
